// File: rtl/midi_uart_rx.sv
// -----------------------------------------------------------------------------
// midi_uart_rx
//
// Serial receiver for the MIDI input line (31 250 baud, 8N1, LSB first, idle
// high). Every correctly framed byte is presented on a one-cycle strobe. Bytes
// are not interpreted here: status, data, running-status and real-time bytes
// all pass through unchanged to the downstream MIDI decoder.
//
// Parameters
//   CLOCK_HZ      system clock frequency
//   BAUD          line rate
//   CLKS_PER_BIT  clocks per bit, derived from CLOCK_HZ/BAUD (even, >= 16)
//
// Ports
//   clock_50_000_000  in   single clock for all state
//   reset_l           in   asynchronous active-low reset
//   rx                in   raw serial line, asynchronous, idle high
//   data_out          out  [7:0] last good byte, held until the next good byte
//   data_out_ready    out  one-cycle strobe, data_out valid in the same cycle
//   framing_error     out  one-cycle strobe when the stop bit samples low
//
// Handshake: data_out_ready is a valid-only strobe with no ready/backpressure
// path. A byte is transferred in exactly the cycle data_out_ready is high; the
// consumer must accept one byte per frame time (10 bit periods).
// -----------------------------------------------------------------------------
module midi_uart_rx #(
    parameter int CLOCK_HZ     = 50_000_000,
    parameter int BAUD         = 31_250,
    parameter int CLKS_PER_BIT = CLOCK_HZ / BAUD
) (
    input  logic       clock_50_000_000,
    input  logic       reset_l,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       data_out_ready,
    output logic       framing_error
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {
        S_RESYNC,
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] clk_cnt, clk_cnt_nxt;
    logic [2:0]       bit_idx, bit_idx_nxt;
    logic [7:0]       shift, shift_nxt;
    logic [7:0]       data_out_nxt;
    logic             data_out_ready_nxt;
    logic             framing_error_nxt;

    // Two-flop synchronizer; resetting to 1 makes the line look idle.
    logic rx_meta;
    logic rx_s;

    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clock_50_000_000 or negedge reset_l) begin
        if (!reset_l) begin
            state          <= S_RESYNC;
            clk_cnt        <= '0;
            bit_idx        <= '0;
            shift          <= '0;
            data_out       <= 8'h00;
            data_out_ready <= 1'b0;
            framing_error  <= 1'b0;
        end else begin
            state          <= state_nxt;
            clk_cnt        <= clk_cnt_nxt;
            bit_idx        <= bit_idx_nxt;
            shift          <= shift_nxt;
            data_out       <= data_out_nxt;
            data_out_ready <= data_out_ready_nxt;
            framing_error  <= framing_error_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        state_nxt          = state;
        clk_cnt_nxt        = clk_cnt;
        bit_idx_nxt        = bit_idx;
        shift_nxt          = shift;
        data_out_nxt       = data_out;
        data_out_ready_nxt = 1'b0;
        framing_error_nxt  = 1'b0;

        case (state)
            // Wait for a full bit period of continuous idle so that a line
            // caught mid-frame (after reset or an error) cannot fake a start.
            S_RESYNC: begin
                if (!rx_s) begin
                    clk_cnt_nxt = '0;
                end else if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = S_IDLE;
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            S_IDLE: begin
                if (!rx_s) begin
                    clk_cnt_nxt = '0;
                    state_nxt   = S_START;
                end
            end

            // Re-check the start bit at its middle; a high sample means the
            // falling edge was a glitch and is dropped silently.
            S_START: begin
                if (clk_cnt == CNT_HALF) begin
                    clk_cnt_nxt = '0;
                    bit_idx_nxt = '0;
                    state_nxt   = rx_s ? S_IDLE : S_DATA;
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            // From the start-bit middle, every full bit period lands on the
            // middle of the next bit.
            S_DATA: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    shift_nxt   = {rx_s, shift[7:1]};
                    if (bit_idx == 3'd7) begin
                        state_nxt = S_STOP;
                    end else begin
                        bit_idx_nxt = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            // Leaving at mid-stop-bit leaves half a bit of slack to catch a
            // back-to-back start edge.
            S_STOP: begin
                if (clk_cnt == CNT_LAST) begin
                    clk_cnt_nxt = '0;
                    if (rx_s) begin
                        data_out_nxt       = shift;
                        data_out_ready_nxt = 1'b1;
                        state_nxt          = S_IDLE;
                    end else begin
                        framing_error_nxt  = 1'b1;
                        state_nxt          = S_RESYNC;
                    end
                end else begin
                    clk_cnt_nxt = clk_cnt + CNT_W'(1);
                end
            end

            default: begin
                clk_cnt_nxt = '0;
                state_nxt   = S_RESYNC;
            end
        endcase
    end

endmodule
